// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller.
// Hits complete in the request cycle; misses run optional write-back then line fill.
module cache_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned LINE_WIDTH = 128,
   parameter int unsigned NUM_LINES  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [WORD_WIDTH-1:0] cpu_wdata,
   output logic [WORD_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [LINE_WIDTH-1:0] mem_wdata,
   input  logic [LINE_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int unsigned WORDS       = LINE_WIDTH / WORD_WIDTH;
   localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
   localparam int unsigned INDEX_BITS  = $clog2(NUM_LINES);
   localparam int unsigned TAG_WIDTH   = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
   localparam int unsigned WSEL_BITS   = OFFSET_BITS - 2;

   typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

   typedef logic [WORDS-1:0][WORD_WIDTH-1:0] line_t;

   state_e                 state_q, state_d;
   logic [NUM_LINES-1:0]   valid_q, valid_d;
   logic [NUM_LINES-1:0]   dirty_q, dirty_d;
   logic [TAG_WIDTH-1:0]   tag_q  [NUM_LINES];
   logic [TAG_WIDTH-1:0]   tag_d  [NUM_LINES];
   line_t                  data_q [NUM_LINES];
   line_t                  data_d [NUM_LINES];
   logic [TAG_WIDTH-1:0]   miss_tag_q, miss_tag_d;
   logic [INDEX_BITS-1:0]  miss_index_q, miss_index_d;

   logic [TAG_WIDTH-1:0]   req_tag;
   logic [INDEX_BITS-1:0]  req_index;
   logic [WSEL_BITS-1:0]   req_word;
   logic                   hit;
   logic                   unused_addr;

   assign req_tag     = cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
   assign req_index   = cpu_addr[OFFSET_BITS +: INDEX_BITS];
   assign req_word    = cpu_addr[OFFSET_BITS-1:2];
   assign unused_addr = ^cpu_addr[1:0];
   assign hit         = cpu_req & valid_q[req_index] & (tag_q[req_index] == req_tag);

   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      tag_d        = tag_q;
      data_d       = data_q;
      miss_tag_d   = miss_tag_q;
      miss_index_d = miss_index_q;
      cpu_ready    = 1'b0;
      cpu_rdata    = '0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;

      unique case (state_q)
         StIdle: begin
            if (hit) begin
               cpu_ready = 1'b1;
               if (cpu_we) begin
                  data_d[req_index][req_word] = cpu_wdata;
                  dirty_d[req_index]          = 1'b1;
               end else begin
                  cpu_rdata = data_q[req_index][req_word];
               end
            end else if (cpu_req) begin
               miss_tag_d   = req_tag;
               miss_index_d = req_index;
               state_d      = (valid_q[req_index] && dirty_q[req_index]) ? StWriteback : StFill;
            end
         end
         StWriteback: begin
            // Victim tag/data stay untouched until the fill lands, so read them straight
            // from the array.
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {tag_q[miss_index_q], miss_index_q, {OFFSET_BITS{1'b0}}};
            mem_wdata = data_q[miss_index_q];
            if (mem_ready) begin
               dirty_d[miss_index_q] = 1'b0;
               state_d               = StFill;
            end
         end
         StFill: begin
            mem_req  = 1'b1;
            mem_addr = {miss_tag_q, miss_index_q, {OFFSET_BITS{1'b0}}};
            if (mem_ready) begin
               data_d[miss_index_q]  = mem_rdata;
               tag_d[miss_index_q]   = miss_tag_q;
               valid_d[miss_index_q] = 1'b1;
               dirty_d[miss_index_q] = 1'b0;
               state_d               = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         valid_q      <= '0;
         dirty_q      <= '0;
         miss_tag_q   <= '0;
         miss_index_q <= '0;
      end else begin
         state_q      <= state_d;
         valid_q      <= valid_d;
         dirty_q      <= dirty_d;
         miss_tag_q   <= miss_tag_d;
         miss_index_q <= miss_index_d;
      end
   end

   // Tag and data storage carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule
